uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter PARITY_EN, default 0, meaning 1 = a parity bit follows the data bits.
REQ-002 SHALL provide parameter PARITY_ODD, default 0, meaning 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-003 SHALL provide port clk_50M  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port sample_tick  input  1  single-cycle enable at 16x baud (the divider's clk_rx output).
REQ-006 SHALL provide port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL provide port data_ack  input  1  consumer has taken rx_data; clears data_valid and the error flags.
REQ-008 SHALL provide port rx_data  output  8  last received byte, LSB received first.
REQ-009 SHALL provide port data_valid  output  1  rx_data holds an unacknowledged byte.
REQ-010 SHALL provide port frame_err  output  1  stop bit of the held frame sampled low.
REQ-011 SHALL provide port parity_err  output  1  parity mismatch on the held frame.
REQ-012 SHALL provide port overrun_err  output  1  a frame completed while data_valid=1 and was discarded.
REQ-013 SHALL provide port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL pass rx through a two-flop synchronizer reset to 1; all decisions use the synchronized value rxs.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP and a 4-bit tick counter advanced only on sample_tick.
REQ-016 IDLE: on any cycle rxs=0, SHALL clear the tick counter and enter START.
REQ-017 START: on the 8th sample_tick (count 7), if rxs=1 SHALL return to IDLE (false start, no flags); otherwise SHALL clear the counter and bit index and enter DATA.
REQ-018 DATA: on every 16th sample_tick after the start midpoint, SHALL shift rxs into bit[index], LSB first; after bit 7 SHALL enter PARITY if PARITY_EN=1, else STOP.
REQ-019 PARITY: at the 16th tick SHALL compare rxs with the XOR of the 8 data bits (inverted when PARITY_ODD=1); a mismatch sets the pending parity error.
REQ-020 STOP: at the 16th tick SHALL sample the stop bit, complete the frame and return to IDLE in the same cycle, without waiting for the end of the stop bit.
REQ-021 On frame completion with data_valid=0, SHALL load rx_data, set data_valid, set frame_err = (stop bit==0) and set parity_err from the pending parity error, all registered one cycle after the stop-sample tick.
REQ-022 On frame completion with data_valid=1 and data_ack=0, SHALL discard the frame, leave rx_data and the error flags unchanged, and set overrun_err.
REQ-023 When data_ack and frame completion coincide, SHALL give the ack priority: load the new frame, keep data_valid=1 and leave overrun_err=0.
REQ-024 data_ack SHALL clear data_valid, frame_err, parity_err and overrun_err on the next edge; data_ack while data_valid=0 has no effect.
REQ-025 The receiver SHALL keep receiving while data_valid=1; a frame with frame_err still returns to IDLE and waits for the next falling edge.

Reset
REQ-026 reset SHALL force IDLE, counter=0, bit index=0, synchronizer flops=1, rx_data=8'h00, and data_valid, frame_err, parity_err, overrun_err and busy to 0.
REQ-027 reset asserted mid-frame SHALL abandon the frame with no flag set; after release, reception resumes at the next falling edge.

Structure
REQ-028 Shared package uart_pkg SHALL hold the state encoding, DATA_BITS=8, OVERSAMPLE=16 and MID_TICK=7, for reuse by the transmitter.
REQ-029 The synchronizer SHALL be a sub-module sync_2ff (reset value parameter, default 1).
REQ-030 The tick counter, bit index and FSM SHALL be inside uart_rx; no internal baud generation.

Verification
REQ-031 Send 0xA5 as 8N1 with a sample_tick every 4 clocks -> rx_data=8'hA5, data_valid=1, all error flags 0, busy=0 after the stop-sample tick.
REQ-032 Drive rx low for 4 ticks, then high -> state returns to IDLE, data_valid stays 0, no flags set.
REQ-033 Send 0x3C with the stop bit at 0 -> rx_data=8'h3C, data_valid=1, frame_err=1.
REQ-034 Use PARITY_EN=1, PARITY_ODD=0 and send 0x07 with parity bit 0 -> parity_err=1; resend with parity bit 1 -> parity_err=0.
REQ-035 Send 0x11 and 0x22 back to back with no data_ack -> rx_data=8'h11, overrun_err=1; pulse data_ack -> all flags 0; repeat with data_ack on the completion cycle -> rx_data=8'h22, overrun_err=0.
REQ-036 Assert reset at data bit 4 of 0xFF -> all outputs return to reset values; the next frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 7;

  localparam logic [3:0] TICK_MID  = 4'(MID_TICK);
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit with a configurable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver with optional parity, holding register and
// frame/parity/overrun error flags cleared by data_ack.
module uart_rx #(
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       rx,
  input  logic       data_ack,
  output logic [7:0] rx_data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun_err,
  output logic       busy
);
  import uart_pkg::*;

  uart_state_t state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [2:0]  idx, idx_nx;
  logic [7:0]  shreg, shreg_nx;
  logic        par_pend, par_nx;
  logic        done;
  logic        rxs;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk_50M),
    .rst (reset),
    .d   (rx),
    .q   (rxs)
  );

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      par_pend <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      idx      <= idx_nx;
      shreg    <= shreg_nx;
      par_pend <= par_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    shreg_nx = shreg;
    par_nx   = par_pend;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rxs) begin
          cnt_nx   = '0;
          state_nx = ST_START;
        end
      end
      ST_START: begin
        if (sample_tick) begin
          if (cnt == TICK_MID) begin
            if (rxs) begin
              state_nx = ST_IDLE;
            end else begin
              cnt_nx   = '0;
              idx_nx   = '0;
              par_nx   = 1'b0;
              state_nx = ST_DATA;
            end
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (sample_tick) begin
          if (cnt == TICK_LAST) begin
            cnt_nx        = '0;
            shreg_nx[idx] = rxs;
            if (idx == BIT_LAST) begin
              state_nx = PARITY_EN ? ST_PARITY : ST_STOP;
            end else begin
              idx_nx = idx + 3'd1;
            end
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (sample_tick) begin
          if (cnt == TICK_LAST) begin
            cnt_nx   = '0;
            par_nx   = rxs ^ (^shreg) ^ PARITY_ODD;
            state_nx = ST_STOP;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (sample_tick) begin
          if (cnt == TICK_LAST) begin
            // Frame completes at the stop-bit midpoint so a following start edge is not missed.
            cnt_nx   = '0;
            done     = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // An ack arriving with a completing frame frees the holding register for it.
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      rx_data     <= '0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else if (done) begin
      if (!data_valid || data_ack) begin
        rx_data     <= shreg;
        data_valid  <= 1'b1;
        frame_err   <= ~rxs;
        parity_err  <= par_pend;
        overrun_err <= 1'b0;
      end else begin
        overrun_err <= 1'b1;
      end
    end else if (data_ack && data_valid) begin
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: 8N1 instance plus an even-parity instance.
module tb_uart_rx;

  logic       clk_50M = 1'b0;
  logic       reset   = 1'b1;
  logic       sample_tick;
  logic       rx      = 1'b1;
  logic       rx_p    = 1'b1;
  logic       data_ack   = 1'b0;
  logic       data_ack_p = 1'b0;
  logic [1:0] div = 2'd0;

  logic [7:0] rx_data, rx_data_p;
  logic       data_valid, frame_err, parity_err, overrun_err, busy;
  logic       data_valid_p, frame_err_p, parity_err_p, overrun_err_p, busy_p;

  // {rx_data, data_valid, frame_err, parity_err, overrun_err, busy}
  logic [12:0] obs_a, obs_p;
  assign obs_a = {rx_data, data_valid, frame_err, parity_err, overrun_err, busy};
  assign obs_p = {rx_data_p, data_valid_p, frame_err_p, parity_err_p, overrun_err_p, busy_p};

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  always #10 clk_50M = ~clk_50M;
  always @(posedge clk_50M) div <= div + 2'd1;
  assign sample_tick = (div == 2'd3);

  uart_rx #(.PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
    .clk_50M     (clk_50M),
    .reset       (reset),
    .sample_tick (sample_tick),
    .rx          (rx),
    .data_ack    (data_ack),
    .rx_data     (rx_data),
    .data_valid  (data_valid),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  uart_rx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .clk_50M     (clk_50M),
    .reset       (reset),
    .sample_tick (sample_tick),
    .rx          (rx_p),
    .data_ack    (data_ack_p),
    .rx_data     (rx_data_p),
    .data_valid  (data_valid_p),
    .frame_err   (frame_err_p),
    .parity_err  (parity_err_p),
    .overrun_err (overrun_err_p),
    .busy        (busy_p)
  );

  // One bit = 16 ticks = 64 clocks. A low stop bit is held only 40 clocks so
  // the line is back high before a re-detected start reaches its midpoint.
  task automatic send_frame(input logic [7:0] b, input bit on_p, input bit has_par,
                            input logic par_bit, input logic stop_bit);
    @(negedge clk_50M);
    if (on_p) rx_p = 1'b0; else rx = 1'b0;
    repeat (64) @(negedge clk_50M);
    for (int i = 0; i < 8; i++) begin
      if (on_p) rx_p = b[i]; else rx = b[i];
      repeat (64) @(negedge clk_50M);
    end
    if (has_par) begin
      if (on_p) rx_p = par_bit; else rx = par_bit;
      repeat (64) @(negedge clk_50M);
    end
    if (!stop_bit) begin
      if (on_p) rx_p = 1'b0; else rx = 1'b0;
      repeat (40) @(negedge clk_50M);
    end
    if (on_p) rx_p = 1'b1; else rx = 1'b1;
    repeat (64) @(negedge clk_50M);
  endtask

  task automatic pulse_ack(input bit on_p);
    @(negedge clk_50M);
    if (on_p) data_ack_p = 1'b1; else data_ack = 1'b1;
    @(negedge clk_50M);
    if (on_p) data_ack_p = 1'b0; else data_ack = 1'b0;
    @(negedge clk_50M);
  endtask

  // Start edge -> 2 sync flops -> START on the 3rd edge; then 8 + 16*8 + 16
  // counted ticks, the last of which is the stop-sample (completion) cycle.
  task automatic ack_on_completion(input int unsigned ticks);
    int unsigned seen  = 0;
    int unsigned guard = 0;
    @(negedge clk_50M);
    repeat (3) @(posedge clk_50M);
    while (seen < ticks && guard < 5000) begin
      @(negedge clk_50M);
      guard++;
      if (sample_tick) seen++;
    end
    n_cmp++;
    if (seen != ticks) begin
      n_mis++;
      $display("FAIL ack_timing: counted %0d ticks, required %0d", seen, ticks);
    end
    data_ack = 1'b1;
    @(negedge clk_50M);
    data_ack = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk_50M);
    n_cmp++;
    if (obs_a !== 13'h0) begin
      n_mis++;
      $display("FAIL reset_state: got %h, expected %h", obs_a, 13'h0);
    end
    n_cmp++;
    if (obs_p !== 13'h0) begin
      n_mis++;
      $display("FAIL reset_state_p: got %h, expected %h", obs_p, 13'h0);
    end
    reset = 1'b0;
    repeat (8) @(negedge clk_50M);
  endtask

  task automatic test_8n1;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (obs_a !== {8'hA5, 5'b10000}) begin
      n_mis++;
      $display("FAIL rx_a5: got %h, expected %h", obs_a, {8'hA5, 5'b10000});
    end
    pulse_ack(1'b0);
    n_cmp++;
    if (obs_a !== {8'hA5, 5'b00000}) begin
      n_mis++;
      $display("FAIL ack_a5: got %h, expected %h", obs_a, {8'hA5, 5'b00000});
    end
  endtask

  task automatic test_false_start;
    @(negedge clk_50M);
    rx = 1'b0;
    repeat (16) @(negedge clk_50M);
    n_cmp++;
    if (obs_a !== {8'hA5, 5'b00001}) begin
      n_mis++;
      $display("FAIL false_start_busy: got %h, expected %h", obs_a, {8'hA5, 5'b00001});
    end
    rx = 1'b1;
    repeat (100) @(negedge clk_50M);
    n_cmp++;
    if (obs_a !== {8'hA5, 5'b00000}) begin
      n_mis++;
      $display("FAIL false_start_idle: got %h, expected %h", obs_a, {8'hA5, 5'b00000});
    end
  endtask

  task automatic test_frame_err;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (64) @(negedge clk_50M);
    n_cmp++;
    if (obs_a !== {8'h3C, 5'b11000}) begin
      n_mis++;
      $display("FAIL frame_err: got %h, expected %h", obs_a, {8'h3C, 5'b11000});
    end
    pulse_ack(1'b0);
    n_cmp++;
    if (obs_a !== {8'h3C, 5'b00000}) begin
      n_mis++;
      $display("FAIL frame_err_ack: got %h, expected %h", obs_a, {8'h3C, 5'b00000});
    end
  endtask

  task automatic test_parity;
    // 0x07 has three ones, so even parity requires a 1 in the parity slot.
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (obs_p !== {8'h07, 5'b10100}) begin
      n_mis++;
      $display("FAIL parity_bad: got %h, expected %h", obs_p, {8'h07, 5'b10100});
    end
    pulse_ack(1'b1);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (obs_p !== {8'h07, 5'b10000}) begin
      n_mis++;
      $display("FAIL parity_good: got %h, expected %h", obs_p, {8'h07, 5'b10000});
    end
    pulse_ack(1'b1);
  endtask

  task automatic test_back_to_back;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (obs_a !== {8'h11, 5'b10010}) begin
      n_mis++;
      $display("FAIL overrun: got %h, expected %h", obs_a, {8'h11, 5'b10010});
    end
    pulse_ack(1'b0);
    n_cmp++;
    if (obs_a !== {8'h11, 5'b00000}) begin
      n_mis++;
      $display("FAIL overrun_ack: got %h, expected %h", obs_a, {8'h11, 5'b00000});
    end
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (obs_a !== {8'h11, 5'b10000}) begin
      n_mis++;
      $display("FAIL b2b_first: got %h, expected %h", obs_a, {8'h11, 5'b10000});
    end
    fork
      send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
      ack_on_completion(152);
    join
    n_cmp++;
    if (obs_a !== {8'h22, 5'b10000}) begin
      n_mis++;
      $display("FAIL ack_priority: got %h, expected %h", obs_a, {8'h22, 5'b10000});
    end
  endtask

  task automatic test_reset_mid_frame;
    fork
      send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
      begin
        repeat (1 + 64 * 5 + 32) @(negedge clk_50M);
        n_cmp++;
        if (obs_a !== {8'h22, 5'b10001}) begin
          n_mis++;
          $display("FAIL pre_reset_busy: got %h, expected %h", obs_a, {8'h22, 5'b10001});
        end
        reset = 1'b1;
        repeat (3) @(negedge clk_50M);
        n_cmp++;
        if (obs_a !== 13'h0) begin
          n_mis++;
          $display("FAIL mid_reset: got %h, expected %h", obs_a, 13'h0);
        end
        reset = 1'b0;
      end
    join
    repeat (32) @(negedge clk_50M);
    n_cmp++;
    if (obs_a !== 13'h0) begin
      n_mis++;
      $display("FAIL post_reset_idle: got %h, expected %h", obs_a, 13'h0);
    end
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (obs_a !== {8'h5A, 5'b10000}) begin
      n_mis++;
      $display("FAIL after_reset_5a: got %h, expected %h", obs_a, {8'h5A, 5'b10000});
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_8n1();
    test_false_start();
    test_frame_err();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
